// File: rtl/core_pkg.sv
// Purpose: shared core constants, OP row payload type, readout FSM encoding
//          and the per-lane ReLU helper used by the OP readout stage.
// Ports:   none (package).
package core_pkg;

  localparam int unsigned COL        = 8;
  localparam int unsigned PSUM_BW    = 16;
  localparam int unsigned ROW_W      = COL * PSUM_BW;
  localparam int unsigned OP_ADDR_BW = 9;
  localparam int unsigned OP_DEPTH   = 340;

  // One OP row: lane i occupies bits [i*PSUM_BW +: PSUM_BW]
  typedef logic [COL-1:0][PSUM_BW-1:0] op_row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } readout_state_e;

  // Zero every negative lane when enabled; positive lanes pass untouched
  function automatic op_row_t relu_row(input op_row_t row, input logic en);
    op_row_t res;
    res = row;
    for (int unsigned i = 0; i < COL; i++) begin
      if (en && row[i][PSUM_BW-1]) begin
        res[i] = '0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/op_skid_fifo.sv
// Purpose: 2-entry output buffer between the OP SRAM read port and the
//          valid/ready stream; absorbs SRAM latency and sink backpressure.
// Ports:   clk, reset   clock, async active-high reset (empties the buffer)
//          i_push/i_data  write one row
//          i_pop          remove head row (ignored when empty)
//          o_data         head row
//          o_full/o_empty occupancy flags
module op_skid_fifo
  import core_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  op_row_t i_data,
  input  logic    i_pop,
  output op_row_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  op_row_t    r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // A push into a full buffer is only legal when the head leaves this cycle
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/op_readout.sv
// Purpose: reads num_rows psum rows from the OP SRAM starting at base_addr,
//          applies optional per-lane ReLU and streams rows over valid/ready.
// Ports:   clk, reset                    clock, async active-high reset
//          start/base_addr/num_rows/relu_en  job request, sampled in IDLE
//          OP_addr/OP_cen/OP_wen/OP_q    OP SRAM read port (1-cycle latency)
//          out_data/out_valid/out_ready  output row stream
//          busy/done                     job status
module op_readout
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OP_ADDR_BW-1:0] base_addr,
  input  logic [OP_ADDR_BW-1:0] num_rows,
  input  logic                  relu_en,
  output logic [OP_ADDR_BW-1:0] OP_addr,
  output logic                  OP_cen,
  output logic                  OP_wen,
  input  logic [ROW_W-1:0]      OP_q,
  output logic [ROW_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  readout_state_e        r_state;
  readout_state_e        w_state_nxt;
  logic [OP_ADDR_BW-1:0] r_addr;
  logic [OP_ADDR_BW-1:0] r_rows_left;
  logic                  r_inflight;
  logic                  r_relu;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  op_row_t               w_head;

  op_skid_fifo u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (op_row_t'(OP_q)),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop = !w_empty && out_ready;

  // Next state and read issue. A read needs a free slot when it lands next
  // cycle; a head leaving this cycle frees one, except when already full.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (num_rows == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        w_issue = (r_rows_left != '0) && !w_full &&
                  (w_empty || !r_inflight || w_pop);
        if (w_issue && (r_rows_left == OP_ADDR_BW'(1))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && (w_empty || (!w_full && w_pop))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job registers: address/row counters, in-flight flag, status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_rows_left <= '0;
      r_inflight  <= 1'b0;
      r_relu      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      if ((r_state == ST_IDLE) && start) begin
        r_addr      <= base_addr;
        r_rows_left <= num_rows;
        r_relu      <= relu_en;
      end else if (w_issue) begin
        r_addr      <= (r_addr == OP_ADDR_BW'(OP_DEPTH - 1)) ? '0
                                                              : r_addr + OP_ADDR_BW'(1);
        r_rows_left <= r_rows_left - OP_ADDR_BW'(1);
      end
    end
  end

  assign OP_addr   = r_addr;
  assign OP_cen    = !w_issue;
  assign OP_wen    = 1'b1;
  assign out_valid = !w_empty;
  assign out_data  = relu_row(w_head, r_relu);
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_op_readout.sv
module tb_op_readout;

  localparam int DEPTH = 340;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [8:0]   base_addr;
  logic [8:0]   num_rows;
  logic         relu_en;
  logic [8:0]   OP_addr;
  logic         OP_cen;
  logic         OP_wen;
  logic [127:0] OP_q;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  op_readout dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .relu_en   (relu_en),
    .OP_addr   (OP_addr),
    .OP_cen    (OP_cen),
    .OP_wen    (OP_wen),
    .OP_q      (OP_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // OP SRAM model: registered read, data visible the cycle after the request
  logic [127:0] mem [DEPTH];
  always @(posedge clk) begin
    if (OP_cen == 1'b0) begin
      OP_q <= (int'(OP_addr) < DEPTH) ? mem[OP_addr] : '1;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_rows[$];
  int           exp_base;
  int           exp_num;
  int           cyc;
  int           issued;
  int           accepted;
  int           first_valid_cyc;
  int           first_issue_cyc;
  int           last_acc_cyc;
  int           done_cyc;
  int           done_cnt;
  logic         prev_stall;
  logic [127:0] prev_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_row(input logic [127:0] row, input logic relu);
    logic [127:0] r;
    shortint      lane;
    r = row;
    for (int i = 0; i < 8; i++) begin
      lane = shortint'(row[i*16 +: 16]);
      if (relu && (lane < 0)) r[i*16 +: 16] = 16'h0000;
    end
    return r;
  endfunction

  function automatic logic ready_of(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 3) == 0;
      default: return $urandom_range(3, 0) != 0;
    endcase
  endfunction

  // Observe one cycle at the falling edge, then advance past the next rising edge
  task automatic cycle();
    int outstanding;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
    end
    if (OP_cen == 1'b0) begin
      chk("op_wen", OP_wen, 1);
      chk("op_addr", OP_addr, (exp_base + issued) % DEPTH);
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
      issued++;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      if (accepted >= exp_num) chk("extra_beat", accepted + 1, exp_num);
      else chk("beat_data", out_data, exp_rows[accepted]);
      accepted++;
      last_acc_cyc = cyc;
    end
    outstanding = issued - accepted;
    chk("outstanding_le2", outstanding <= 2, 1);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input int base, input int num, input logic relu, input int rmode,
                         input int restart_at, input int reset_after_beats);
    logic timed_out;
    exp_rows.delete();
    for (int i = 0; i < num; i++) exp_rows.push_back(ref_row(mem[(base + i) % DEPTH], relu));
    exp_base = base;  exp_num = num;
    issued = 0;  accepted = 0;  cyc = 0;
    first_valid_cyc = -1;  first_issue_cyc = -1;  last_acc_cyc = -1;
    done_cyc = -1;  done_cnt = 0;  prev_stall = 1'b0;

    chk("busy_before_start", busy, 0);
    start = 1'b1;  base_addr = 9'(base);  num_rows = 9'(num);  relu_en = relu;
    out_ready = ready_of(rmode, 0);
    cycle();
    chk("busy_after_start", busy, 1);

    timed_out = 1'b1;
    for (int n = 1; n < num * 8 + 60; n++) begin
      if (reset_after_beats > 0 && accepted >= reset_after_beats) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_cen", OP_cen, 1);
        chk("midrst_addr", OP_addr, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        prev_stall = 1'b0;
        return;
      end
      // Inputs other than start may wander freely once start has been sampled
      base_addr = 9'($urandom_range(339, 0));
      num_rows  = 9'($urandom_range(20, 1));
      relu_en   = 1'($urandom);
      start     = (n == restart_at);
      out_ready = ready_of(rmode, n);
      cycle();
      if (done_cyc >= 0 && cyc > done_cyc) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk("job_timeout", timed_out, 0);
    chk("beats_accepted", accepted, num);
    chk("reads_issued", issued, num);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("done_low_after", done, 0);
    if (num == 0) begin
      chk("zero_done_cyc", done_cyc, 1);
    end else begin
      chk("done_after_last", done_cyc, last_acc_cyc + 1);
      if (rmode == 0) begin
        chk("first_issue_cyc", first_issue_cyc, 1);
        chk("first_valid_cyc", first_valid_cyc, 3);
        chk("no_bubbles", last_acc_cyc, 3 + num - 1);
      end
    end
  endtask

  initial begin
    logic [15:0] edge_lanes [8];
    int v;
    edge_lanes = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000,
                   16'h0001, 16'h8001, 16'h1234, 16'hFEDC};
    for (int r = 0; r < DEPTH; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        v = 8 * r + i + 1;
        mem[r][i*16 +: 16] = (i % 2 == 0) ? 16'(-v) : 16'(v);
      end
    end
    for (int i = 0; i < 8; i++) mem[4][i*16 +: 16] = edge_lanes[i];

    reset = 1'b1;  start = 1'b0;  base_addr = '0;  num_rows = '0;
    relu_en = 1'b0;  out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cen", OP_cen, 1);
    chk("rst_wen", OP_wen, 1);
    chk("rst_addr", OP_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_job(0, 4, 1'b0, 0, -1, 0);     // plain stream, full rate
    run_job(0, 4, 1'b1, 0, -1, 0);     // ReLU on the same rows
    run_job(4, 1, 1'b1, 0, -1, 0);     // lane sign boundaries, single row
    run_job(4, 1, 1'b0, 0, -1, 0);
    run_job(0, 6, 1'b0, 1, -1, 0);     // ready 1,0,0 backpressure
    run_job(338, 4, 1'b0, 0, -1, 0);   // address wrap
    run_job(0, 0, 1'b0, 0, 1, 0);      // empty job, start during DONE
    run_job(10, 5, 1'b0, 0, 3, 0);     // start while streaming is ignored
    run_job(20, 6, 1'b1, 1, -1, 2);    // reset mid-job
    run_job(20, 6, 1'b1, 0, -1, 0);    // clean job afterwards
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(339, 0), $urandom_range(12, 1), 1'($urandom), 2, -1, 0);
    end
    run_job(100, 340, 1'b1, 0, -1, 0); // whole SRAM, wraps once

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
